// File: rtl/bus_responder.sv
// Bus slave for the core: RAM window plus an 8-byte I/O page (TX FIFO, RX holding register, status, timer).
// Define RESPONDER_TIMER_EN to build the free-running timer and its coherent-read latch.
module bus_responder #(
  parameter int          RAM_AW  = 9,
  parameter logic [15:0] IO_BASE = 16'hF000,
  parameter int          FIFO_AW = 3
) (
  input  logic        ph0,
  input  logic        resetb,
  input  logic [15:0] address,
  input  logic        read_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int RAM_DEPTH = 2 ** RAM_AW;
  localparam int DEPTH     = 2 ** FIFO_AW;

  logic [7:0]         ram [RAM_DEPTH];
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         rx_byte;
  logic               rx_full, overrun;
  logic [7:0]         tim_lo, tim_hi;

  logic               io_hit, ram_hit;
  logic [2:0]         io_off;
  logic               fifo_full, fifo_empty;
  logic               tx_push, tx_pop, rx_pop;

  // The I/O page wins over RAM when the two windows overlap.
  assign io_hit  = (address[15:3] == IO_BASE[15:3]);
  assign ram_hit = !io_hit && (address[15:RAM_AW] == '0);
  assign hit     = io_hit | ram_hit;
  assign io_off  = address[2:0];

  assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);

  // TX handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_data holds the head and stays stable until that edge.
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = !read_en && io_hit && (io_off == 3'd0) && (!fifo_full || tx_pop);
  assign rx_pop   = read_en && io_hit && (io_off == 3'd2);

  always_ff @(posedge ph0) begin
    if (resetb && !read_en && ram_hit) ram[address[RAM_AW-1:0]] <= wdata;
  end

  always_ff @(posedge ph0) begin
    if (resetb && tx_push) fifo_mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ph0 or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A capture coinciding with a pop leaves a fresh, un-overrun byte behind.
  always_ff @(posedge ph0 or negedge resetb) begin
    if (!resetb) begin
      rx_byte <= 8'h00;
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end else if (rx_valid) begin
      rx_byte <= rx_data;
      rx_full <= 1'b1;
      overrun <= rx_pop ? 1'b0 : (overrun | rx_full);
    end else if (rx_pop) begin
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef RESPONDER_TIMER_EN
  logic [15:0] timer;
  logic [7:0]  tim_latch;
  logic        tim_lo_rd;

  assign tim_lo_rd = read_en && io_hit && (io_off == 3'd3);

  // Reading the low byte snapshots the high byte so a two-read sequence is coherent.
  always_ff @(posedge ph0 or negedge resetb) begin
    if (!resetb) begin
      timer     <= 16'h0000;
      tim_latch <= 8'h00;
    end else begin
      timer <= timer + 16'd1;
      if (tim_lo_rd) tim_latch <= timer[15:8];
    end
  end

  assign tim_lo = timer[7:0];
  assign tim_hi = tim_latch;
`else
  assign tim_lo = 8'h00;
  assign tim_hi = 8'h00;
`endif

  always_comb begin
    rdata = 8'hFF;
    if (io_hit) begin
      case (io_off)
        3'd1:    rdata = {rx_full, overrun, fifo_full, fifo_empty, 4'(count)};
        3'd2:    rdata = rx_byte;
        3'd3:    rdata = tim_lo;
        3'd4:    rdata = tim_hi;
        default: rdata = 8'h00;
      endcase
    end else if (ram_hit) begin
      rdata = ram[address[RAM_AW-1:0]];
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: RAM, unmapped space, TX FIFO scoreboard, RX register, timer, async reset.
module tb_bus_responder;

  localparam logic [15:0] IDLE_ADDR = 16'h8000;

  logic        ph0 = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] address = IDLE_ADDR;
  logic        read_en = 1'b1;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          model_count = 0;
  logic [7:0]  exp_q[$];

  bus_responder dut (
    .ph0      (ph0),
    .resetb   (resetb),
    .address  (address),
    .read_en  (read_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  // Clock / reset
  always #5 ph0 = ~ph0;

  task automatic do_reset();
    resetb = 1'b0;
    address = IDLE_ADDR;
    read_en = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    exp_q.delete();
    model_count = 0;
    @(posedge ph0);
    @(posedge ph0);
    #1 resetb = 1'b1;
  endtask

  // Scoreboard: every transfer seen on the TX port must match the oldest expected byte.
  always @(negedge ph0) begin
    if (resetb && tx_valid && tx_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %02h, expected no transfer", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        model_count--;
        if (tx_data !== e) begin
          n_err++;
          $display("FAIL tx_order: got %02h, expected %02h", tx_data, e);
        end
      end
    end
  end

  function automatic logic [7:0] exp_status(input logic rxf, input logic ov, input int cnt);
    return {rxf, ov, (cnt == 8), (cnt == 0), 4'(cnt)};
  endfunction

  // Driver tasks: called at posedge+1, return at posedge+1.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a;
    read_en = 1'b0;
    wdata = d;
    @(posedge ph0);
    #1;
    address = IDLE_ADDR;
    read_en = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
    address = a;
    read_en = 1'b1;
    @(negedge ph0);
    d = rdata;
    h = hit;
    @(posedge ph0);
    #1;
    address = IDLE_ADDR;
  endtask

  task automatic push_byte(input logic [7:0] d);
    if (model_count < 8 || tx_ready) begin
      exp_q.push_back(d);
      model_count++;
    end
    bus_write(16'hF000, d);
  endtask

  task automatic rx_strobe(input logic [7:0] d);
    rx_data = d;
    rx_valid = 1'b1;
    @(posedge ph0);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       h;
    resetb = 1'b0;
    @(negedge ph0);
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
    do_reset();
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h10) begin n_err++; $display("FAIL reset_status: got %02h, expected 10", d); end
    bus_read(16'hF004, d, h);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL reset_timhi: got %02h, expected 00", d); end
  endtask

  task automatic test_ram();
    logic [7:0] d;
    logic       h;
    bus_write(16'h0010, 8'hA5);
    bus_read(16'h0010, d, h);
    n_cmp++;
    if (d !== 8'hA5 || h !== 1'b1) begin n_err++; $display("FAIL ram_rd: got %02h/%b, expected a5/1", d, h); end
    bus_read(16'h8000, d, h);
    n_cmp++;
    if (d !== 8'hFF || h !== 1'b0) begin n_err++; $display("FAIL unmapped_rd: got %02h/%b, expected ff/0", d, h); end
    bus_write(16'h0210, 8'h5A);
    bus_read(16'h0010, d, h);
    n_cmp++;
    if (d !== 8'hA5) begin n_err++; $display("FAIL ram_alias: got %02h, expected a5", d); end
    bus_read(16'h0200, d, h);
    n_cmp++;
    if (d !== 8'hFF || h !== 1'b0) begin n_err++; $display("FAIL ram_top_edge: got %02h/%b, expected ff/0", d, h); end
    bus_write(16'h01FF, 8'h3D);
    bus_read(16'h01FF, d, h);
    n_cmp++;
    if (d !== 8'h3D || h !== 1'b1) begin n_err++; $display("FAIL ram_last: got %02h/%b, expected 3d/1", d, h); end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      logic [7:0]  v;
      a = 16'($urandom_range(32, 500));
      v = 8'($urandom_range(0, 255));
      bus_write(a, v);
      bus_read(a, d, h);
      n_cmp++;
      if (d !== v) begin n_err++; $display("FAIL ram_rand: addr %04h got %02h, expected %02h", a, d, v); end
    end
    bus_read(16'hF000, d, h);
    n_cmp++;
    if (d !== 8'h00 || h !== 1'b1) begin n_err++; $display("FAIL txdata_rd: got %02h/%b, expected 00/1", d, h); end
    bus_write(16'hF006, 8'h99);
    bus_read(16'hF006, d, h);
    n_cmp++;
    if (d !== 8'h00 || h !== 1'b1) begin n_err++; $display("FAIL io_reserved: got %02h/%b, expected 00/1", d, h); end
  endtask

  task automatic test_fifo_fill_drain();
    logic [7:0] d;
    logic       h;
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== exp_status(1'b0, 1'b0, model_count)) begin
      n_err++; $display("FAIL status_full: got %02h, expected %02h", d, exp_status(1'b0, 1'b0, model_count));
    end
    tx_ready = 1'b1;
    repeat (8) @(posedge ph0);
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL drain_done: got valid %b left %0d, expected 0 and 0", tx_valid, exp_q.size());
    end
    tx_ready = 1'b0;
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h10) begin n_err++; $display("FAIL status_drained: got %02h, expected 10", d); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d;
    logic       h;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    tx_ready = 1'b1;
    push_byte(8'hEE);
    tx_ready = 1'b0;
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h28) begin n_err++; $display("FAIL status_pushpop: got %02h, expected 28", d); end
    tx_ready = 1'b1;
    repeat (8) @(posedge ph0);
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL pushpop_drain: got valid %b left %0d, expected 0 and 0", tx_valid, exp_q.size());
    end
  endtask

  task automatic test_empty_push();
    tx_ready = 1'b1;
    address = 16'hF000;
    read_en = 1'b0;
    wdata = 8'h77;
    exp_q.push_back(8'h77);
    model_count++;
    @(negedge ph0);
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL no_fallthrough: got %b, expected 0", tx_valid); end
    @(posedge ph0);
    #1;
    address = IDLE_ADDR;
    read_en = 1'b1;
    @(posedge ph0);
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL single_pass: got valid %b left %0d, expected 0 and 0", tx_valid, exp_q.size());
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic       h;
    rx_strobe(8'h55);
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h90) begin n_err++; $display("FAIL rx_full_status: got %02h, expected 90", d); end
    bus_read(16'hF002, d, h);
    n_cmp++;
    if (d !== 8'h55) begin n_err++; $display("FAIL rx_single: got %02h, expected 55", d); end
    rx_strobe(8'h3C);
    rx_strobe(8'h7E);
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'hD0) begin n_err++; $display("FAIL rx_overrun_status: got %02h, expected d0", d); end
    bus_read(16'hF002, d, h);
    n_cmp++;
    if (d !== 8'h7E) begin n_err++; $display("FAIL rx_overrun_data: got %02h, expected 7e", d); end
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h10) begin n_err++; $display("FAIL rx_cleared: got %02h, expected 10", d); end
    rx_strobe(8'hA1);
    rx_data = 8'hB2;
    rx_valid = 1'b1;
    bus_read(16'hF002, d, h);
    rx_valid = 1'b0;
    n_cmp++;
    if (d !== 8'hA1) begin n_err++; $display("FAIL rx_same_edge_old: got %02h, expected a1", d); end
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h90) begin n_err++; $display("FAIL rx_same_edge_status: got %02h, expected 90", d); end
    bus_read(16'hF002, d, h);
    n_cmp++;
    if (d !== 8'hB2) begin n_err++; $display("FAIL rx_same_edge_new: got %02h, expected b2", d); end
  endtask

  task automatic test_timer();
    logic [7:0] lo, hi;
    logic       h;
    do_reset();
    repeat (300) @(posedge ph0);
    #1;
    bus_read(16'hF003, lo, h);
    repeat (250) @(posedge ph0);
    #1;
    bus_read(16'hF004, hi, h);
`ifdef RESPONDER_TIMER_EN
    n_cmp++;
    if ({hi, lo} !== 16'h012C) begin n_err++; $display("FAIL timer_pair: got %04h, expected 012c", {hi, lo}); end
    // Timer is 300 + 1 + 250 + 1 = 552 here.
    bus_read(16'hF003, lo, h);
    bus_read(16'hF004, hi, h);
    n_cmp++;
    if ({hi, lo} !== 16'h0228) begin n_err++; $display("FAIL timer_relatch: got %04h, expected 0228", {hi, lo}); end
`else
    n_cmp++;
    if ({hi, lo} !== 16'h0000 || h !== 1'b1) begin
      n_err++; $display("FAIL timer_absent: got %04h/%b, expected 0000/1", {hi, lo}, h);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic       h;
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i));
    tx_ready = 1'b1;
    repeat (2) @(posedge ph0);
    #2;
    n_cmp++;
    if (model_count != 5 || tx_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_drain: got count %0d valid %b, expected 5 and 1", model_count, tx_valid);
    end
    resetb = 1'b0;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL async_tx_valid: got %b, expected 0", tx_valid); end
    exp_q.delete();
    model_count = 0;
    tx_ready = 1'b0;
    @(posedge ph0);
    #1 resetb = 1'b1;
    bus_read(16'hF001, d, h);
    n_cmp++;
    if (d !== 8'h10) begin n_err++; $display("FAIL status_after_reset: got %02h, expected 10", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_fill_drain();
    test_push_pop_full();
    test_empty_push();
    test_rx();
    test_timer();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
